// File: rtl/inst_rom.sv
// inst_rom: instruction memory that answers the CPU fetch port and is filled
// through a byte-serial program-load port.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   inst_en_i         fetch enable; inst_o is 0 while low
//   inst_addr_i[31:0] fetch byte address
//   inst_o[31:0]      fetched word (combinational), NOP_INST when not served
//   load_start_i      pulse: begin or restart a program load
//   load_valid_i      load byte valid
//   load_byte_i[7:0]  load byte, little-endian within each word
//   load_last_i       marks the final byte of the program
//   load_ready_o      high while a load is in progress
//   load_done_o       one-cycle pulse after the last byte is taken
//   load_err_o        sticky: program was larger than the memory
//   load_words_o      number of valid words loaded
module inst_rom #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_INST   = 32'h03400000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_en_i,
  input  logic [31:0]         inst_addr_i,
  output logic [31:0]         inst_o,
  input  logic                load_start_i,
  input  logic                load_valid_i,
  input  logic [7:0]          load_byte_i,
  input  logic                load_last_i,
  output logic                load_ready_o,
  output logic                load_done_o,
  output logic                load_err_o,
  output logic [DEPTH_LOG2:0] load_words_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state, state_nxt;
  logic [1:0]            lane;
  logic [23:0]           lo_bytes;   // lanes 0..2 of the word being assembled
  logic [DEPTH_LOG2:0]   words;
  logic                  done_q;
  logic                  err_q;
  logic                  accept;
  logic                  full;
  logic                  wr_en;
  logic [31:0]           wr_word;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  assign load_ready_o = (state == LOAD);
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign load_words_o = words;

  // A start in the same cycle as a byte wins; the byte is thrown away.
  assign accept = load_valid_i & load_ready_o & ~load_start_i;
  // The word count doubles as the write address: both advance together and
  // both clear on start. Its MSB set means every word has been written.
  assign full   = words[DEPTH_LOG2];
  assign wr_en  = accept & ~full & ((lane == 2'd3) | load_last_i);

  // Lanes above the current one are zero, which covers a short final word.
  always_comb begin
    wr_word = '0;
    case (lane)
      2'd0: wr_word = {24'h0, load_byte_i};
      2'd1: wr_word = {16'h0, load_byte_i, lo_bytes[7:0]};
      2'd2: wr_word = {8'h0,  load_byte_i, lo_bytes[15:0]};
      2'd3: wr_word = {load_byte_i, lo_bytes};
      default: wr_word = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (load_start_i)
      state_nxt = LOAD;
    else if (accept && load_last_i)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lane     <= '0;
      lo_bytes <= '0;
      words    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= accept & load_last_i;
      if (load_start_i) begin
        lane  <= '0;
        words <= '0;
        err_q <= 1'b0;
      end else if (accept) begin
        if (full) begin
          err_q <= 1'b1;
        end else if (wr_en) begin
          lane  <= '0;
          words <= words + 1'b1;
        end else begin
          lane <= lane + 2'd1;
          case (lane)
            2'd0:    lo_bytes[7:0]   <= load_byte_i;
            2'd1:    lo_bytes[15:8]  <= load_byte_i;
            default: lo_bytes[23:16] <= load_byte_i;
          endcase
        end
      end
    end
  end

  // Storage is not reset; the word count hides anything not yet loaded.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[words[DEPTH_LOG2-1:0]] <= wr_word;
  end

  assign rd_idx = inst_addr_i[DEPTH_LOG2+1:2];

  always_comb begin
    inst_o = '0;
    if (inst_en_i) begin
      inst_o = NOP_INST;
      if (state == RUN && inst_addr_i[1:0] == 2'b00 &&
          inst_addr_i[31:DEPTH_LOG2+2] == '0 &&
          {1'b0, rd_idx} < words)
        inst_o = mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: a default-depth instance and a 4-word instance
// share stimulus so overflow can be exercised on the small one.
module tb_inst_rom;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_en = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_last = 1'b0;

  logic [31:0] inst_big, inst_sml;
  logic        rdy_big, rdy_sml, done_big, done_sml, err_big, err_sml;
  logic [10:0] words_big;
  logic [2:0]  words_sml;

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [31:0] NOP = 32'h03400000;

  always #5 clk = ~clk;

  inst_rom u_big (
    .clk(clk), .rst(rst), .inst_en_i(inst_en), .inst_addr_i(inst_addr),
    .inst_o(inst_big), .load_start_i(load_start), .load_valid_i(load_valid),
    .load_byte_i(load_byte), .load_last_i(load_last), .load_ready_o(rdy_big),
    .load_done_o(done_big), .load_err_o(err_big), .load_words_o(words_big)
  );

  inst_rom #(.DEPTH_LOG2(2)) u_sml (
    .clk(clk), .rst(rst), .inst_en_i(inst_en), .inst_addr_i(inst_addr),
    .inst_o(inst_sml), .load_start_i(load_start), .load_valid_i(load_valid),
    .load_byte_i(load_byte), .load_last_i(load_last), .load_ready_o(rdy_sml),
    .load_done_o(done_sml), .load_err_o(err_sml), .load_words_o(words_sml)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic fetch_big(input string tag, input logic [31:0] a, input logic [31:0] exp);
    inst_en = 1'b1; inst_addr = a; #1;
    chk(tag, inst_big, exp);
  endtask

  task automatic fetch_sml(input string tag, input logic [31:0] a, input logic [31:0] exp);
    inst_en = 1'b1; inst_addr = a; #1;
    chk(tag, inst_sml, exp);
  endtask

  task automatic start_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  // Returns on the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    @(negedge clk); load_valid = 1'b1; load_byte = b; load_last = last;
    @(negedge clk); load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    // reset state
    inst_en = 1'b1; inst_addr = '0; #1;
    chk("rst_nop", inst_big, NOP);
    chk("rst_ready", {31'h0, rdy_big}, 32'h0);
    chk("rst_words", {21'h0, words_big}, 32'h0);
    chk("rst_err", {31'h0, err_big}, 32'h0);
    inst_en = 1'b0; #1;
    chk("rst_en0", inst_big, 32'h0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    fetch_big("idle_nop", 32'h0, NOP);

    // two full words
    start_load();
    chk("load_ready", {31'h0, rdy_big}, 32'h1);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
    chk("done_pulse", {31'h0, done_big}, 32'h1);
    chk("run_ready", {31'h0, rdy_big}, 32'h0);
    @(negedge clk);
    chk("done_clear", {31'h0, done_big}, 32'h0);
    fetch_big("a0", 32'h0, 32'h04030201);
    fetch_big("a4", 32'h4, 32'h08070605);
    fetch_big("a8_unloaded", 32'h8, NOP);
    fetch_big("a2_misalign", 32'h2, NOP);
    chk("words2", {21'h0, words_big}, 32'd2);
    inst_en = 1'b0; #1;
    chk("run_en0", inst_big, 32'h0);

    // short final word with idle gaps
    start_load();
    send_byte(8'hAA, 1'b0); repeat (2) @(negedge clk);
    send_byte(8'hBB, 1'b0); repeat (2) @(negedge clk);
    send_byte(8'hCC, 1'b1);
    fetch_big("partial", 32'h0, 32'h00CCBBAA);
    fetch_big("old_hidden", 32'h4, NOP);
    chk("words1", {21'h0, words_big}, 32'd1);

    // overflow on the 4-word instance
    start_load();
    for (int i = 0; i <= 16; i++) send_byte(8'(i), i == 16);
    chk("ovf_done", {31'h0, done_sml}, 32'h1);
    chk("ovf_err", {31'h0, err_sml}, 32'h1);
    chk("ovf_words", {29'h0, words_sml}, 32'd4);
    fetch_sml("ovf_a12", 32'd12, 32'h0F0E0D0C);
    fetch_sml("ovf_a0_nowrap", 32'd0, 32'h03020100);
    fetch_sml("ovf_a16", 32'd16, NOP);
    chk("big_noerr", {31'h0, err_big}, 32'h0);
    chk("big_words5", {21'h0, words_big}, 32'd5);
    fetch_big("big_a16", 32'd16, 32'h00000010);

    // restart mid-load; the byte coincident with start is dropped
    start_load();
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
    @(negedge clk); load_start = 1'b1; load_valid = 1'b1; load_byte = 8'h77;
    @(negedge clk); load_start = 1'b0; load_valid = 1'b0;
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    fetch_big("restart_a0", 32'h0, 32'h44332211);
    chk("restart_words", {21'h0, words_big}, 32'd1);
    fetch_big("restart_a4", 32'h4, NOP);

    // asynchronous reset mid-load
    start_load();
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i), 1'b0);
    chk("pre_rst_words", {21'h0, words_big}, 32'd1);
    #2; rst = 1'b0; #1;
    chk("arst_ready", {31'h0, rdy_big}, 32'h0);
    chk("arst_words", {21'h0, words_big}, 32'h0);
    chk("arst_done", {31'h0, done_big}, 32'h0);
    chk("arst_err_sml", {31'h0, err_sml}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    fetch_big("post_rst_a0", 32'h0, NOP);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 The block SHALL be the instruction-memory responder to the CPU fetch port (inst address/enable out, instruction in), with a byte-serial program-load port.
REQ-002 Parameter DEPTH_LOG2, default 10, gives log2 of memory depth in 32-bit words.
REQ-003 Parameter NOP_INST, default 32'h03400000, is the instruction returned for any non-served fetch.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 inst_en_i  in  1  fetch enable from CPU.
REQ-008 inst_addr_i  in  32  fetch byte address.
REQ-009 inst_o  out  32  fetched instruction.
REQ-010 load_start_i  in  1  single-cycle pulse: begin or restart a program load.
REQ-011 load_valid_i  in  1  load byte valid.
REQ-012 load_byte_i  in  8  load data byte.
REQ-013 load_last_i  in  1  qualifies the final byte of the program.
REQ-014 load_ready_o  out  1  block accepts a load byte.
REQ-015 load_done_o  out  1  one-cycle pulse: load complete.
REQ-016 load_err_o  out  1  sticky: load overflowed memory.
REQ-017 load_words_o  out  DEPTH_LOG2+1  number of valid words loaded.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN; reset state IDLE.
REQ-019 IDLE/RUN -> LOAD on load_start_i; LOAD -> LOAD restart on load_start_i (counters cleared, partial word discarded).
REQ-020 Entering LOAD SHALL clear word address, byte lane, load_words_o, load_err_o.
REQ-021 load_ready_o SHALL be 1 exactly in LOAD; byte accepted when load_valid_i & load_ready_o; valid-low cycles change nothing.
REQ-022 Accepted bytes SHALL assemble little-endian: lane 0 -> bits 7:0 ... lane 3 -> bits 31:24.
REQ-023 On acceptance of lane 3, word SHALL be written to mem[word address], word address and load_words_o incremented, lane reset to 0.
REQ-024 On acceptance with load_last_i=1 at lane <3, unfilled upper lanes SHALL be zero, word written, load_words_o incremented.
REQ-025 Accepted last byte SHALL cause LOAD -> RUN at that edge and load_done_o=1 during the following cycle only.
REQ-026 When load_words_o equals 2^DEPTH_LOG2, further accepted bytes SHALL be dropped (no write, no wrap to word 0) and load_err_o set; last byte still completes the load.
REQ-027 load_start_i and accepted byte in same cycle: start wins, byte discarded.
REQ-028 inst_o SHALL be combinational from inst_addr_i (zero latency; consumed by fetch register on the same edge).
REQ-029 inst_o SHALL be 32'h0 when inst_en_i=0.
REQ-030 With inst_en_i=1: inst_o SHALL be mem[inst_addr_i[DEPTH_LOG2+1:2]] only when state is RUN, inst_addr_i[1:0]=0, inst_addr_i[31:DEPTH_LOG2+2]=0, and word index < load_words_o; otherwise NOP_INST.
REQ-031 Memory array SHALL not be reset; unloaded words are never visible (REQ-030).

Reset
REQ-032 rst low SHALL immediately force IDLE, lane 0, word address 0, load_words_o 0, load_ready_o 0, load_done_o 0, load_err_o 0, independent of clk.
REQ-033 Reset during LOAD SHALL abandon the load; after release, fetches return NOP_INST until a new load completes.

Verification
REQ-034 Reset, inst_en_i=1, addr 0 -> inst_o=32'h03400000, load_ready_o=0; inst_en_i=0 -> inst_o=0.
REQ-035 Start; bytes 01..08, last on 08 -> done pulse next cycle; addr 0=32'h04030201, addr 4=32'h08070605, addr 8=NOP, addr 2=NOP, load_words_o=2.
REQ-036 Start; bytes AA,BB,CC (last on CC), valid low 2 cycles between each -> addr 0=32'h00CCBBAA, load_words_o=1.
REQ-037 DEPTH_LOG2=2; 17 bytes 00..10, last on 10 -> load_err_o=1, load_words_o=4, addr 12=32'h0F0E0D0C, addr 16=NOP.
REQ-038 Reset asserted mid-load after 5 bytes -> outputs at reset values asynchronously; addr 0 -> NOP after release.
REQ-039 load_start_i mid-load after 3 bytes, then 4 bytes 11,22,33,44 last -> addr 0=32'h44332211, load_words_o=1.
